// File: rtl/sc_pkg.sv
// Shared stochastic-computing definitions: bitstream width, decoder state
// encoding and the bipolar offset used when presenting signed results.
package sc_pkg;

   localparam int SC_N = 12;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } dec_state_t;

   // Midpoint of a 2^n window: a stream with p = 0.5 decodes to zero.
   function automatic int sc_bipolar_offset(input int n);
      return 1 << (n - 1);
   endfunction

endpackage

// File: rtl/sc_ones_counter.sv
// Ones counter for the stochastic decoder: synchronous clear, enable-gated
// increment; wide enough that a full window of ones does not overflow.
module sc_ones_counter #(
   parameter int W = 13
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         clear,
   input  logic         enable,
   output logic [W-1:0] count
);

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary decoder: counts ones over 2^N accepted bits.
// Define SC_DEC_BIPOLAR_EN to present the result offset by -2^(N-1) (signed).
module sc_stream_decoder
   import sc_pkg::*;
#(
   parameter int N = SC_N
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   input  logic         bit_valid,
   input  logic         bit_in,
   output logic         busy,
   output logic         done,
   output logic [N:0]   value
);

   dec_state_t   state;
   dec_state_t   state_next;
   logic [N-1:0] sample_cnt;
   logic [N:0]   ones_cnt;
   logic         accept;
   logic         final_bit;
   logic         cnt_clear;
   logic         cnt_en;
   logic [N:0]   result;

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; start is only honoured while idle
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start)     state_next = ACCUM;
         ACCUM:   if (final_bit) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Control decode
   always_comb begin
      accept    = 1'b0;
      final_bit = 1'b0;
      cnt_clear = 1'b0;
      cnt_en    = 1'b0;
      case (state)
         IDLE: cnt_clear = start;
         ACCUM: begin
            accept    = bit_valid;
            final_bit = bit_valid && (sample_cnt == '1);
            cnt_en    = bit_valid && bit_in;
         end
         default: ;
      endcase
   end

   // sample_cnt wraps back to zero exactly on the final bit of the window
   always_ff @(posedge clock) begin
      if (reset || cnt_clear) begin
         sample_cnt <= '0;
      end else if (accept) begin
         sample_cnt <= sample_cnt + 1'b1;
      end
   end

   sc_ones_counter #(
      .W (N + 1)
   ) u_ones (
      .clock  (clock),
      .reset  (reset),
      .clear  (cnt_clear),
      .enable (cnt_en),
      .count  (ones_cnt)
   );

   // The final bit is still in flight, so fold it in at load time
`ifdef SC_DEC_BIPOLAR_EN
   localparam logic [N:0] OFFSET = (N + 1)'(sc_bipolar_offset(N));
   logic signed [N:0] signed_result;
   always_comb begin
      signed_result = $signed(ones_cnt + (N + 1)'(bit_in)) - $signed(OFFSET);
      result        = $unsigned(signed_result);
   end
`else
   always_comb begin
      result = ones_cnt + (N + 1)'(bit_in);
   end
`endif

   // Registered outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         busy  <= 1'b0;
         done  <= 1'b0;
         value <= '0;
      end else begin
         busy <= (state_next == ACCUM);
         done <= final_bit;
         if (final_bit) begin
            value <= result;
         end
      end
   end

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Self-checking bench for sc_stream_decoder: behavioural window model with a
// per-cycle compare, plus literal checks on directed windows.
module tb_sc_stream_decoder;

   localparam int N   = 12;
   localparam int WIN = 1 << N;
`ifdef SC_DEC_BIPOLAR_EN
   localparam bit BIP = 1'b1;
`else
   localparam bit BIP = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic       bit_valid;
   logic       bit_in;
   logic       busy;
   logic       done;
   logic [N:0] value;

   int tests    = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   // Behavioural model state
   bit m_busy;
   bit m_done;
   int m_value;
   int m_cnt;
   int m_ones;

   sc_stream_decoder #(.N(N)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .bit_valid (bit_valid),
      .bit_in    (bit_in),
      .busy      (busy),
      .done      (done),
      .value     (value)
   );

   always #5 clock = ~clock;

   function automatic int dut_val();
      if (BIP) return int'($signed(value));
      return int'(value);
   endfunction

   function automatic int bitrev12(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 12; i++) if (v[i]) r |= (1 << (11 - i));
      return r;
   endfunction

   // Model: a window is 2^N accepted bits; result is the ones count,
   // shifted by half a window in the bipolar build.
   always @(posedge clock) begin
      m_done <= 1'b0;
      if (reset) begin
         m_busy  <= 1'b0;
         m_value <= 0;
         m_cnt   <= 0;
         m_ones  <= 0;
      end else if (!m_busy) begin
         if (start) begin
            m_busy <= 1'b1;
            m_cnt  <= 0;
            m_ones <= 0;
         end
      end else if (bit_valid) begin
         if (m_cnt + 1 == WIN) begin
            m_busy  <= 1'b0;
            m_done  <= 1'b1;
            m_value <= m_ones + int'(bit_in) - (BIP ? WIN / 2 : 0);
         end
         m_cnt  <= m_cnt + 1;
         m_ones <= m_ones + int'(bit_in);
      end
   end

   always @(negedge clock) begin
      if (chk_en) begin
         tests++;
         if (busy !== m_busy || done !== m_done || dut_val() != m_value) begin
            failures++;
            $display("FAIL cycle_check t=%0t busy/done/value got %0b/%0b/%0d want %0b/%0b/%0d",
                     $time, busy, done, dut_val(), m_busy, m_done, m_value);
         end
      end
   end

   task automatic chk(input string name, input int got, input int want);
      tests++;
      if (got != want) begin
         failures++;
         $display("FAIL %s got %0d want %0d", name, got, want);
      end
   endtask

   // mode: 0 ones, 1 zeros, 2 alternating 1/0, 3 VDC < 0x40*16, 4 random
   // stall: 0 none, 1 every third cycle, 2 random
   task automatic do_window(input int mode, input int stall, input bit start_bit_hi,
                            input int mid_start_at, output int lat);
      int acc;
      int cyc;
      bit v;
      start     = 1'b1;
      bit_valid = start_bit_hi;
      bit_in    = start_bit_hi;
      @(negedge clock);
      start = 1'b0;
      lat   = 1;
      acc   = 0;
      cyc   = 0;
      while (acc < WIN && cyc < 40000) begin
         cyc++;
         case (stall)
            1:       v = (cyc % 3 != 0);
            2:       v = ($urandom % 4 != 0);
            default: v = 1'b1;
         endcase
         bit_valid = v;
         if (v) begin
            case (mode)
               0:       bit_in = 1'b1;
               1:       bit_in = 1'b0;
               2:       bit_in = (acc % 2 == 0);
               3:       bit_in = (bitrev12(acc) < 8'h40 * 16);
               default: bit_in = $urandom % 2;
            endcase
            acc++;
         end else begin
            bit_in = $urandom % 2;
         end
         if (mode == 4) start = ($urandom % 64 == 0);
         else           start = (mid_start_at >= 0 && v && acc == mid_start_at);
         @(negedge clock);
         lat++;
      end
      bit_valid = 1'b0;
      bit_in    = 1'b0;
      start     = 1'b0;
      if (acc < WIN) begin
         failures++;
         tests++;
         $display("FAIL window_timeout got %0d bits want %0d", acc, WIN);
      end
      chk("done_after_last_bit", int'(done), 1);
   endtask

   initial begin
      int lat;
      reset     = 1'b1;
      start     = 1'b0;
      bit_valid = 1'b0;
      bit_in    = 1'b0;
      repeat (3) @(negedge clock);
      reset  = 1'b0;
      chk_en = 1'b1;
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_value", int'(value), 0);

      do_window(0, 0, 1'b0, -1, lat);
      chk("ones_latency", lat, 4097);
      chk("ones_value", dut_val(), BIP ? 2048 : 4096);
      @(negedge clock);

      do_window(1, 0, 1'b0, -1, lat);
      chk("zeros_value", dut_val(), BIP ? -2048 : 0);
      chk("zeros_raw", int'(value), BIP ? 13'h1800 : 0);

      do_window(2, 1, 1'b0, -1, lat);
      chk("alt_stall_value", dut_val(), BIP ? 0 : 2048);
      chk("alt_stall_latency", lat, 6144);
      @(negedge clock);

      do_window(0, 0, 1'b0, -1, lat);
      do_window(1, 0, 1'b1, 100, lat);
      chk("startbit_ignored", dut_val(), BIP ? -2048 : 0);
      chk("midstart_latency", lat, 4097);
      @(negedge clock);

      do_window(3, 0, 1'b0, -1, lat);
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start     = 1'b0;
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      repeat (1000) @(negedge clock);
      reset     = 1'b1;
      bit_valid = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      chk("midreset_busy", int'(busy), 0);
      chk("midreset_done", int'(done), 0);
      chk("midreset_value", int'(value), 0);
      repeat (2) @(negedge clock);
      chk("midreset_no_done", int'(done), 0);
      do_window(0, 0, 1'b0, -1, lat);
      chk("after_reset_ones", dut_val(), BIP ? 2048 : 4096);
      @(negedge clock);

      do_window(3, 0, 1'b0, -1, lat);
      chk("vdc_x40_value", dut_val(), BIP ? -1024 : 1024);
      repeat (3) @(negedge clock);
      chk("value_holds", dut_val(), BIP ? -1024 : 1024);

      for (int w = 0; w < 3; w++) begin
         do_window(4, 2, 1'($urandom % 2), -1, lat);
         repeat ($urandom % 3) @(negedge clock);
      end
      repeat (2) @(negedge clock);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
